// File: rtl/ahb_sub_mem_bridge.sv
// AHB subordinate bridging one AHB slot onto the nyu-mem request/ready port.
// Pipelined address/data phases, HSEL window decode, byte-lane strobes from
// HSIZE/HADDR and a two-cycle ERROR response for illegal transfers.
// Optional stall watchdog: define SUB_MEM_TIMEOUT_EN to abort a request that
// sees no MemReady for TIMEOUT consecutive cycles.
module ahb_sub_mem_bridge #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 'h10000,
    parameter int                    TIMEOUT    = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [ADDR_WIDTH-1:0]     HADDR,
    input  logic                      HWRITE,
    input  logic [1:0]                HTRANS,
    input  logic [2:0]                HSIZE,
    input  logic [DATA_WIDTH-1:0]     HWDATA,
    input  logic                      HREADY,
    output logic [DATA_WIDTH-1:0]     HRDATA,
    output logic                      HREADYOUT,
    output logic [1:0]                HRESP,
    output logic [ADDR_WIDTH-1:0]     MemAddr,
    output logic                      MemWrite,
    output logic [DATA_WIDTH/8-1:0]   MemWStrb,
    output logic [DATA_WIDTH-1:0]     MemWData,
    output logic                      MemReq,
    input  logic [DATA_WIDTH-1:0]     MemRData,
    input  logic                      MemReady
);

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e                  stateQ, stateD;
    logic [ADDR_WIDTH-1:0]   addrQ, addrD;
    logic                    writeQ, writeD;
    logic [STRB_W-1:0]       strbQ, strbD;
    logic [DATA_WIDTH-1:0]   hrdataQ, hrdataD;

    logic                    sampleValid;
    logic                    canAccept;
    logic                    legal;
    logic [ADDR_WIDTH-1:0]   relAddr;
    logic [ADDR_WIDTH-1:0]   alignMask;
    logic [STRB_W-1:0]       newStrb;
    logic                    timeoutHit;
    int                      laneIdx;
    int                      beatBytes;
    logic                    unusedBits;

    assign sampleValid = HSEL && HTRANS[1] && HREADY;
    assign canAccept   = (stateQ == S_IDLE) || (stateQ == S_DONE) || (stateQ == S_ERR2);
    assign relAddr     = HADDR - MEM_BASE;
    assign alignMask   = ~({ADDR_WIDTH{1'b1}} << HSIZE);
    assign legal       = (HSIZE <= 3'(LANE_BITS))
                      && ((HADDR & alignMask) == '0)
                      && (relAddr < MEM_SIZE);

    // Byte-lane mask of the incoming beat: 2^HSIZE lanes starting at the low address bits
    always_comb begin
        newStrb   = '0;
        laneIdx   = int'(HADDR[LANE_BITS-1:0]);
        beatBytes = 1 << HSIZE;
        for (int i = 0; i < STRB_W; i++) begin
            newStrb[i] = (i >= laneIdx) && (i < laneIdx + beatBytes);
        end
    end

`ifdef SUB_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stallCntQ, stallCntD;

    assign timeoutHit = (stateQ == S_REQ) && !MemReady && (stallCntQ == CNT_W'(TIMEOUT - 1));
    assign stallCntD  = ((stateQ == S_REQ) && !MemReady) ? stallCntQ + 1'b1 : '0;

    // Consecutive stalled REQ cycles; zero whenever the bridge is not stalled in REQ
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stallCntQ <= '0;
        end else begin
            stallCntQ <= stallCntD;
        end
    end

    assign unusedBits = HTRANS[0];
`else
    assign timeoutHit = 1'b0;
    assign unusedBits = ^{HTRANS[0], 32'(TIMEOUT)};
`endif

    // State and request-field registers; reset aborts any request in flight
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stateQ  <= S_IDLE;
            addrQ   <= '0;
            writeQ  <= 1'b0;
            strbQ   <= '0;
            hrdataQ <= '0;
        end else begin
            stateQ  <= stateD;
            addrQ   <= addrD;
            writeQ  <= writeD;
            strbQ   <= strbD;
            hrdataQ <= hrdataD;
        end
    end

    // Next-state: accept address phases when ready, complete or abort the memory request
    always_comb begin
        stateD  = stateQ;
        addrD   = addrQ;
        writeD  = writeQ;
        strbD   = strbQ;
        hrdataD = hrdataQ;
        case (stateQ)
            S_REQ: begin
                if (MemReady) begin
                    if (!writeQ) begin
                        hrdataD = MemRData;
                    end
                    stateD = S_DONE;
                end else if (timeoutHit) begin
                    stateD = S_ERR1;
                end
            end
            S_ERR1: begin
                stateD = S_ERR2;
            end
            default: begin
                if (canAccept && sampleValid) begin
                    if (legal) begin
                        stateD = S_REQ;
                        addrD  = {relAddr[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
                        writeD = HWRITE;
                        strbD  = HWRITE ? newStrb : '0;
                    end else begin
                        stateD = S_ERR1;
                    end
                end else begin
                    stateD = S_IDLE;
                end
            end
        endcase
    end

    assign MemReq    = (stateQ == S_REQ);
    assign MemWrite  = MemReq && writeQ;
    assign MemWStrb  = MemReq ? strbQ : '0;
    assign MemAddr   = addrQ;
    assign MemWData  = HWDATA;
    assign HRDATA    = hrdataQ;
    assign HREADYOUT = !((stateQ == S_REQ) || (stateQ == S_ERR1));
    assign HRESP     = ((stateQ == S_ERR1) || (stateQ == S_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: doc/ahb_sub_mem_bridge.md
# ahb_sub_mem_bridge

Parametrised AHB subordinate bridging one AHB slot to the nyu-mem memory controller request/ready port. It is the successor of the first-generation memory subordinate. It adds:
- proper address/data phase pipelining
- HSEL decoding against a configurable window
- byte-lane write strobes derived from HSIZE/HADDR
- two-cycle ERROR responses for illegal transfers
- an optional stall watchdog

## Interface
- ADDR_WIDTH, 32, AHB and memory address width
- DATA_WIDTH, 32, data bus width; 32 or 64 only
- MEM_BASE, 'h0, first byte address of the decoded window
- MEM_SIZE, 'h10000, window size in bytes; power of two
- TIMEOUT, 256, watchdog limit in cycles (used only with the macro)

- HCLK  in  1  clock, all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  subordinate select
- HADDR  in  ADDR_WIDTH  address
- HWRITE  in  1  write/read
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HWDATA  in  DATA_WIDTH  write data (valid in data phase)
- HREADY  in  1  bus-level ready from the interconnect
- HRDATA  out  DATA_WIDTH  read data
- HREADYOUT  out  1  this subordinate's ready
- HRESP  out  2  00 OKAY, 01 ERROR
- MemAddr  out  ADDR_WIDTH  byte address relative to MEM_BASE, lane bits zeroed
- MemWrite  out  1  write request qualifier
- MemWStrb  out  DATA_WIDTH/8  byte enables
- MemWData  out  DATA_WIDTH  write data
- MemReq  out  1  request, held until MemReady
- MemRData  in  DATA_WIDTH  read data, valid with MemReady on reads
- MemReady  in  1  request completed this cycle

## Operation
**Address-phase sample:** HSEL && HTRANS[1] && HREADY. The bridge registers HADDR, HWRITE and HSIZE. HTRANS IDLE/BUSY or !HSEL gives a zero-wait OKAY.

**Legality checks** (on the sampled address phase):
- HSIZE > log2(DATA_WIDTH/8) → ERROR.
- HADDR not aligned to 2^HSIZE → ERROR.
- (HADDR − MEM_BASE) ≥ MEM_SIZE, unsigned → ERROR.

**Strobes:** 2^HSIZE consecutive bits set, starting at lane HADDR[log2(DATA_WIDTH/8)-1:0]. Reads drive MemWStrb = 0.

**FSM:**
- IDLE
  - Legal sample → REQ.
  - Illegal sample → ERR1.
- REQ
  - MemReq=1, MemWrite=registered HWRITE, MemWData=HWDATA.
  - MemReady=1 → capture MemRData into HRDATA (reads only) → DONE.
- DONE
  - HREADYOUT=1, HRESP=OKAY.
  - New legal sample → REQ; illegal sample → ERR1; otherwise → IDLE.
- ERR1
  - HREADYOUT=0, HRESP=ERROR, no MemReq → ERR2.
- ERR2
  - HREADYOUT=1, HRESP=ERROR.
  - Samples the next address phase like IDLE.

Only one outstanding memory request at a time. HRDATA holds its last captured value and is never cleared except by reset.

## Timing
- **Reset values:** HRDATA=0, HREADYOUT=1, HRESP=00, MemReq=0, MemWrite=0, MemWStrb=0, MemAddr=0. MemWData follows HWDATA.
- **Minimum data phase:** 2 cycles (REQ with MemReady=1, then DONE), i.e. one wait state.
- **Stalls:** each extra cycle MemReady stays low adds one wait state.
- **REQ outputs:** HREADYOUT=0 and HRESP=00 every cycle in REQ.
- **Request stability:** MemAddr, MemWrite, MemWStrb and MemWData are stable for the whole time MemReq is high.
- **Back-to-back:** a transfer sampled in DONE/ERR2 issues MemReq the next cycle, giving a 2-cycle throughput per transfer.
- **Spurious ready:** MemReady outside REQ is ignored.
- **Error response:** exactly 2 cycles (ERR1, ERR2).
- **Reset mid-transfer:** all outputs return to reset values immediately (asynchronously) and the FSM goes to IDLE. The memory controller must treat MemReq falling as an abort.

## Configuration
SUB_MEM_TIMEOUT_EN
- **Defined:** a counter of width clog2(TIMEOUT+1) counts consecutive REQ cycles with MemReady=0. It clears on entering REQ.
  - When the count reaches TIMEOUT, MemReq drops that cycle's successor and the FSM → ERR1, so the master sees ERROR.
  - A MemReady arriving after the abort is ignored.
- **Undefined:** no counter exists; REQ waits indefinitely and TIMEOUT is unused.

## Test plan
- **Single read:** HADDR=MEM_BASE+8, HSIZE=2, MemReady high on first REQ cycle, MemRData='hDEADBEEF → MemAddr=8, MemReq high 1 cycle, HREADYOUT low 1 cycle, then HRDATA='hDEADBEEF with OKAY.
- **Byte write:** HADDR=MEM_BASE+'h13, HSIZE=0, HWDATA='hAB000000 → MemWStrb=4'b1000, MemWrite=1, MemAddr='h10.
- **Stall then pipeline:** MemReady delayed 3 cycles → 4 wait states, request fields stable throughout. A second read sampled in DONE issues MemReq on the following cycle.
- **Illegal transfers:** HADDR=MEM_BASE+MEM_SIZE, then HSIZE=1 at an odd address, then HSIZE=3 with DATA_WIDTH=32 → each gives ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), with MemReq never asserted.
- **Watchdog:** with SUB_MEM_TIMEOUT_EN and TIMEOUT=4, hold MemReady low → ERROR response after 4 REQ cycles. Without the macro, the bench sees no response until MemReady.
- **Reset mid-transfer:** assert HRESETn=0 during REQ → MemReq=0 and HREADYOUT=1 without a clock edge; the next transfer after reset completes normally.
